// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: request/grant, divisor-load and serial-line bundle
// shared by the scheduler and whatever drives its two requesters.
interface uart_tx_sched_if;
    logic       req0;
    logic [7:0] data0;
    logic       gnt0;
    logic       req1;
    logic [7:0] data1;
    logic       gnt1;
    logic       div_load;
    logic [7:0] div_val;
    logic       baud_tick;
    logic       txd;
    logic       busy;

    modport master (
        output req0, data0, req1, data1, div_load, div_val,
        input  gnt0, gnt1, baud_tick, txd, busy
    );

    modport slave (
        input  req0, data0, req1, data1, div_load, div_val,
        output gnt0, gnt1, baud_tick, txd, busy
    );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-requester round-robin 8N1 UART transmitter with
// a 16x oversample tick divisor that can be replaced at runtime.
module uart_tx_sched #(
    parameter int DIV = 78
) (
    input logic            clk,
    input logic            rst,
    uart_tx_sched_if.slave bus
);

    localparam logic [7:0] DIV_RST = (DIV < 2) ? 8'd2 : 8'(DIV);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] div;
    logic [7:0] pend;
    logic       pend_vld;
    logic [7:0] sh;
    logic [3:0] sub;
    logic [2:0] bidx;
    logic       last;
    logic       txd_r;
    logic       busy_r;

    logic       tick;
    logic       bit_end;
    logic       pick0;
    logic       pick1;
    logic [7:0] cnt_nxt;
    logic [7:0] ld_div;
    logic [7:0] idle_div;

    assign tick     = (cnt == div - 8'd1);
    assign bit_end  = tick && (sub == 4'd15);
    assign cnt_nxt  = tick ? 8'd0 : cnt + 8'd1;
    assign ld_div   = (bus.div_val < 8'd2) ? 8'd2 : bus.div_val;
    assign idle_div = bus.div_load ? ld_div : pend;

    // last==1 means requester 1 was granted last, so 0 wins a tie
    assign pick0 = bus.req0 && (!bus.req1 || last);
    assign pick1 = bus.req1 && (!bus.req0 || !last);

    // grants are decided in the IDLE cycle itself so txd falls next cycle
    assign bus.gnt0      = rst && (state == IDLE) && pick0;
    assign bus.gnt1      = rst && (state == IDLE) && pick1;
    assign bus.baud_tick = tick;
    assign bus.txd       = txd_r;
    assign bus.busy      = busy_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            div      <= DIV_RST;
            pend     <= 8'd0;
            pend_vld <= 1'b0;
            sh       <= 8'd0;
            sub      <= 4'd0;
            bidx     <= 3'd0;
            last     <= 1'b1;
            txd_r    <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (tick) begin
                sub <= sub + 4'd1;
            end
            if (bus.div_load && state != IDLE) begin
                pend     <= ld_div;
                pend_vld <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (bus.div_load) begin
                        div <= ld_div;
                        cnt <= 8'd0;
                    end
                    if (pick0 || pick1) begin
                        sh     <= pick0 ? bus.data0 : bus.data1;
                        last   <= pick1;
                        cnt    <= 8'd0;
                        sub    <= 4'd0;
                        state  <= START;
                        txd_r  <= 1'b0;
                        busy_r <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        bidx  <= 3'd0;
                        txd_r <= sh[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bidx == 3'd7) begin
                            state <= STOP;
                            txd_r <= 1'b1;
                        end else begin
                            bidx  <= bidx + 3'd1;
                            txd_r <= sh[bidx + 3'd1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        // a load in this very cycle is newer than pend
                        if (pend_vld || bus.div_load) begin
                            div      <= idle_div;
                            cnt      <= 8'd0;
                            pend_vld <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized bench for uart_tx_sched against a
// frame-level model (bit index = elapsed cycles / (16*div)).
module tb_uart_tx_sched;

    localparam int D0 = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   last_m = 1;

    logic cap_txd[$];
    logic cap_busy[$];
    int   cap_wait;
    int   cap_xgnt;
    logic cap_g0, cap_g1, cap_gbusy, cap_itxd, cap_ibusy;

    uart_tx_sched_if bus();

    uart_tx_sched #(.DIV(D0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // expected txd k cycles after the grant cycle, k = 1 .. 160*dv
    function automatic logic exp_txd(input logic [7:0] d, input int k,
                                     input int dv);
        int b;
        b = (k - 1) / (16 * dv);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    // round-robin model: returns requester id, -1 when nobody asks
    function automatic int pick(input logic r0, input logic r1);
        if (r0 && r1) return (last_m == 0) ? 1 : 0;
        if (r1) return 1;
        if (r0) return 0;
        return -1;
    endfunction

    task automatic capture(input int maxw, input int len, input bit drop);
        cap_txd.delete();
        cap_busy.delete();
        cap_wait = -1;
        cap_xgnt = 0;
        cap_g0 = 1'b0;
        cap_g1 = 1'b0;
        cap_gbusy = 1'bx;
        cap_itxd = 1'bx;
        cap_ibusy = 1'bx;
        for (int i = 0; i < maxw; i++) begin
            @(negedge clk);
            if (bus.gnt0 || bus.gnt1) begin
                cap_wait = i;
                cap_g0 = bus.gnt0;
                cap_g1 = bus.gnt1;
                cap_gbusy = bus.busy;
                break;
            end
        end
        if (cap_wait < 0) return;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            cap_txd.push_back(bus.txd);
            cap_busy.push_back(bus.busy);
            if (bus.gnt0 || bus.gnt1) cap_xgnt++;
            if (k == 1) begin
                if (drop) begin
                    bus.req0 = 1'b0;
                    bus.req1 = 1'b0;
                end
                bus.div_load = 1'b0;
            end
        end
        if (drop) begin
            @(negedge clk);
            cap_itxd = bus.txd;
            cap_ibusy = bus.busy;
        end
    endtask

    task automatic measure_tick(output int sp);
        int prev;
        prev = -1;
        sp = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (bus.baud_tick) begin
                if (prev >= 0) begin
                    sp = i - prev;
                    break;
                end
                prev = i;
            end
        end
    endtask

    task automatic load_div(input logic [7:0] v);
        @(posedge clk);
        #1;
        bus.div_load = 1'b1;
        bus.div_val = v;
        @(posedge clk);
        #1;
        bus.div_load = 1'b0;
    endtask

    task automatic test_reset();
        int first, second;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.data0 = 8'h00;
        bus.data1 = 8'h00;
        bus.div_load = 1'b0;
        bus.div_val = 8'h00;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.txd, bus.busy, bus.gnt0, bus.gnt1, bus.baud_tick} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_outputs: txd,busy,gnt0,gnt1,tick=%b want 10000",
                     {bus.txd, bus.busy, bus.gnt0, bus.gnt1, bus.baud_tick});
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        last_m = 1;
        first = -1;
        second = -1;
        for (int i = 1; i <= 4 * D0 && second < 0; i++) begin
            @(negedge clk);
            if (bus.baud_tick) begin
                if (first < 0) first = i;
                else second = i;
            end
        end
        checks++;
        if (first !== D0) begin
            errors++;
            $display("FAIL first_tick: cycle %0d want %0d", first, D0);
        end
        checks++;
        if (second !== 2 * D0) begin
            errors++;
            $display("FAIL tick_period: second tick cycle %0d want %0d", second, 2 * D0);
        end
    endtask

    task automatic test_frame_a5();
        int bad, fk;
        @(posedge clk);
        #1;
        bus.data0 = 8'hA5;
        bus.req0 = 1'b1;
        capture(50, 160 * D0, 1);
        checks++;
        if (cap_wait < 0 || cap_g0 !== 1'b1 || cap_g1 !== 1'b0) begin
            errors++;
            $display("FAIL a5_grant: wait=%0d gnt0=%b gnt1=%b want gnt0 only",
                     cap_wait, cap_g0, cap_g1);
        end
        last_m = 0;
        bad = 0;
        fk = 0;
        if (cap_txd.size() != 160 * D0) bad = 1;
        else foreach (cap_txd[j])
            if (cap_txd[j] !== exp_txd(8'hA5, j + 1, D0) || cap_busy[j] !== 1'b1) begin
                if (bad == 0) fk = j + 1;
                bad++;
            end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL a5_frame: %0d bad samples, first k=%0d, size %0d want %0d",
                     bad, fk, cap_txd.size(), 160 * D0);
        end
        checks++;
        if (cap_xgnt !== 0) begin
            errors++;
            $display("FAIL a5_single_pulse: %0d extra grants want 0", cap_xgnt);
        end
        checks++;
        if (cap_itxd !== 1'b1 || cap_ibusy !== 1'b0) begin
            errors++;
            $display("FAIL a5_idle: txd=%b busy=%b want 1 0", cap_itxd, cap_ibusy);
        end
    endtask

    task automatic test_random();
        int r, e, bad, fk;
        logic [7:0] d0, d1, d;
        for (int n = 0; n < 6; n++) begin
            r = $urandom_range(1, 3);
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            @(posedge clk);
            #1;
            bus.data0 = d0;
            bus.data1 = d1;
            bus.req0 = r[0];
            bus.req1 = r[1];
            e = pick(r[0], r[1]);
            d = (e == 0) ? d0 : d1;
            capture(50, 160 * D0, 1);
            checks++;
            if (cap_wait < 0 || cap_g0 !== (e == 0) || cap_g1 !== (e == 1)) begin
                errors++;
                $display("FAIL rand_grant[%0d]: req=%0d gnt0=%b gnt1=%b want id %0d",
                         n, r, cap_g0, cap_g1, e);
            end
            last_m = e;
            bad = 0;
            fk = 0;
            if (cap_txd.size() != 160 * D0) bad = 1;
            else foreach (cap_txd[j])
                if (cap_txd[j] !== exp_txd(d, j + 1, D0) || cap_busy[j] !== 1'b1) begin
                    if (bad == 0) fk = j + 1;
                    bad++;
                end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rand_frame[%0d]: data %h, %0d bad samples, first k=%0d",
                         n, d, bad, fk);
            end
        end
    endtask

    task automatic test_back_to_back();
        int e, bad, fk;
        logic [7:0] d0, d1, d;
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        @(posedge clk);
        #1;
        bus.data0 = d0;
        bus.data1 = d1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            e = pick(1'b1, 1'b1);
            d = (e == 0) ? d0 : d1;
            capture(50, 160 * D0, 0);
            checks++;
            if (cap_wait < 0 || cap_g0 !== (e == 0) || cap_g1 !== (e == 1)) begin
                errors++;
                $display("FAIL b2b_order[%0d]: gnt0=%b gnt1=%b want id %0d",
                         n, cap_g0, cap_g1, e);
            end
            last_m = e;
            if (n > 0) begin
                checks++;
                if (cap_wait !== 0 || cap_gbusy !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_spacing[%0d]: extra wait %0d busy=%b want 0 0 (%0d cycles)",
                             n, cap_wait, cap_gbusy, 160 * D0 + 1);
                end
            end
            bad = 0;
            fk = 0;
            if (cap_txd.size() != 160 * D0) bad = 1;
            else foreach (cap_txd[j])
                if (cap_txd[j] !== exp_txd(d, j + 1, D0) || cap_busy[j] !== 1'b1) begin
                    if (bad == 0) fk = j + 1;
                    bad++;
                end
            checks++;
            if (bad != 0 || cap_xgnt != 0) begin
                errors++;
                $display("FAIL b2b_frame[%0d]: %0d bad samples first k=%0d, %0d extra grants",
                         n, bad, fk, cap_xgnt);
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_div_pending();
        int bad, fk, e;
        logic [7:0] d;
        for (int f = 0; f < 2; f++) begin
            d = 8'($urandom);
            @(posedge clk);
            #1;
            bus.data0 = d;
            bus.req0 = 1'b1;
            e = pick(1'b1, 1'b0);
            if (f == 0) begin
                fork
                    capture(50, 160 * D0, 1);
                    begin
                        repeat (100) @(posedge clk);
                        #1;
                        bus.div_load = 1'b1;
                        bus.div_val = 8'd200;
                        @(posedge clk);
                        #1 bus.div_val = 8'd8;
                        @(posedge clk);
                        #1 bus.div_load = 1'b0;
                    end
                join
            end else begin
                capture(50, 160 * 8, 1);
            end
            checks++;
            if (cap_wait < 0 || cap_g0 !== (e == 0)) begin
                errors++;
                $display("FAIL pend_grant[%0d]: gnt0=%b want 1", f, cap_g0);
            end
            last_m = e;
            bad = 0;
            fk = 0;
            if (cap_txd.size() != 160 * ((f == 0) ? D0 : 8)) bad = 1;
            else foreach (cap_txd[j])
                if (cap_txd[j] !== exp_txd(d, j + 1, (f == 0) ? D0 : 8)
                    || cap_busy[j] !== 1'b1) begin
                    if (bad == 0) fk = j + 1;
                    bad++;
                end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL pend_frame[%0d]: div want %0d, %0d bad samples first k=%0d",
                         f, (f == 0) ? D0 : 8, bad, fk);
            end
        end
        load_div(8'(D0));
    endtask

    task automatic test_div_zero();
        int bad, fk, sp, e;
        logic [7:0] d;
        d = 8'($urandom);
        @(posedge clk);
        #1;
        bus.data1 = d;
        bus.req1 = 1'b1;
        bus.div_load = 1'b1;
        bus.div_val = 8'd0;
        e = pick(1'b0, 1'b1);
        capture(50, 160 * 2, 1);
        checks++;
        if (cap_wait < 0 || cap_g1 !== 1'b1 || cap_g0 !== 1'b0) begin
            errors++;
            $display("FAIL zero_grant: gnt0=%b gnt1=%b want gnt1 only", cap_g0, cap_g1);
        end
        last_m = e;
        bad = 0;
        fk = 0;
        if (cap_txd.size() != 320) bad = 1;
        else foreach (cap_txd[j])
            if (cap_txd[j] !== exp_txd(d, j + 1, 2) || cap_busy[j] !== 1'b1) begin
                if (bad == 0) fk = j + 1;
                bad++;
            end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL zero_frame: %0d bad samples first k=%0d (32-cycle bits)", bad, fk);
        end
        measure_tick(sp);
        checks++;
        if (sp !== 2) begin
            errors++;
            $display("FAIL zero_tick: spacing %0d want 2", sp);
        end
        load_div(8'd1);
        measure_tick(sp);
        checks++;
        if (sp !== 2) begin
            errors++;
            $display("FAIL one_tick: spacing %0d want 2", sp);
        end
        load_div(8'd3);
        measure_tick(sp);
        checks++;
        if (sp !== 3) begin
            errors++;
            $display("FAIL three_tick: spacing %0d want 3", sp);
        end
        load_div(8'(D0));
    endtask

    task automatic test_reset_mid();
        int bad, fk;
        logic pre;
        logic [7:0] d;
        @(posedge clk);
        #1;
        bus.data0 = 8'hC3;
        bus.req0 = 1'b1;
        capture(50, 16 * D0 * 4 + 8, 1);
        checks++;
        if (cap_wait < 0 || cap_g0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_grant: gnt0=%b want 1", cap_g0);
        end
        last_m = 0;
        bus.div_load = 1'b1;
        bus.div_val = 8'd8;
        @(posedge clk);
        #1 bus.div_load = 1'b0;
        @(negedge clk);
        #2;
        pre = bus.txd;
        checks++;
        if (pre !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_bit3: txd=%b busy=%b want 0 1", pre, bus.busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.txd, bus.busy, bus.gnt0, bus.gnt1, bus.baud_tick} !== 5'b10000) begin
            errors++;
            $display("FAIL mid_abort: txd,busy,gnt0,gnt1,tick=%b want 10000",
                     {bus.txd, bus.busy, bus.gnt0, bus.gnt1, bus.baud_tick});
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        last_m = 1;
        d = 8'($urandom);
        bus.data1 = d;
        bus.req1 = 1'b1;
        capture(50, 160 * D0, 1);
        checks++;
        if (cap_wait < 0 || cap_g1 !== 1'b1 || cap_g0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_regrant: gnt0=%b gnt1=%b want gnt1 only", cap_g0, cap_g1);
        end
        last_m = 1;
        bad = 0;
        fk = 0;
        if (cap_txd.size() != 160 * D0) bad = 1;
        else foreach (cap_txd[j])
            if (cap_txd[j] !== exp_txd(d, j + 1, D0) || cap_busy[j] !== 1'b1) begin
                if (bad == 0) fk = j + 1;
                bad++;
            end
        checks++;
        if (bad != 0 || cap_itxd !== 1'b1) begin
            errors++;
            $display("FAIL mid_frame: %0d bad samples first k=%0d, idle txd=%b",
                     bad, fk, cap_itxd);
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_random();
        test_back_to_back();
        test_div_pending();
        test_div_zero();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter DIV, default 78, giving the system-clock cycles per 16x oversample tick (12 MHz / 9600 / 16).
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port req0, input, 1, requester 0 has a byte pending.
REQ-005 SHALL have port data0, input, 8, requester 0 byte.
REQ-006 SHALL have port gnt0, output, 1, one-cycle pulse: data0 accepted.
REQ-007 SHALL have port req1, input, 1, requester 1 has a byte pending.
REQ-008 SHALL have port data1, input, 8, requester 1 byte.
REQ-009 SHALL have port gnt1, output, 1, one-cycle pulse: data1 accepted.
REQ-010 SHALL have port div_load, input, 1, request to replace the tick divisor.
REQ-011 SHALL have port div_val, input, 8, new divisor value.
REQ-012 SHALL have port baud_tick, output, 1, one-cycle pulse per oversample tick.
REQ-013 SHALL have port txd, output, 1, serial line, 8N1, LSB first, idle high.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 Tick counter cnt (8 bit) SHALL count 0..div-1 and wrap to 0; baud_tick SHALL be high in the cycle where cnt==div-1.
REQ-016 Active divisor div SHALL be taken as max(value,2); div_val of 0 or 1 SHALL load 2.
REQ-017 States SHALL be IDLE, START, DATA, STOP.
REQ-018 In IDLE with req0|req1, the block SHALL pulse exactly one gnt, latch that requester's data, clear cnt and the 4-bit tick sub-counter, and enter START on the next cycle.
REQ-019 Arbitration SHALL be round-robin: if both request, grant the requester not granted last; with a single request, grant it regardless of history.
REQ-020 txd SHALL be 0 in START, data bit i in DATA (i=0..7), 1 in STOP and IDLE.
REQ-021 Each bit SHALL last exactly 16*div cycles: the sub-counter advances on baud_tick, and the bit ends on the baud_tick where the sub-counter==15.
REQ-022 DATA SHALL advance through bits 0..7 and then enter STOP; STOP SHALL end by entering IDLE.
REQ-023 For a grant in cycle T, txd SHALL fall at T+1 and the stop bit SHALL end at T+160*div, then IDLE for at least 1 cycle, giving a minimum frame-start spacing of 160*div+1 cycles.
REQ-024 A requester may hold req high through its grant; no second grant SHALL occur until the next IDLE cycle.
REQ-025 div_load in IDLE SHALL apply at that edge (div updated, cnt cleared); if a grant occurs in the same cycle, the grant SHALL also occur and the new div SHALL time the frame.
REQ-026 div_load outside IDLE SHALL store div_val in a pending register; it SHALL be applied on entry to IDLE, and the last load SHALL win.
REQ-027 gnt0 and gnt1 SHALL never be high in the same cycle.

Reset
REQ-028 With rst low, the block SHALL asynchronously force: state IDLE, txd=1, busy=0, gnt0=gnt1=0, baud_tick=0, cnt=0, div=DIV, pending cleared, and last-grant pointer set so requester 0 wins the first tie.
REQ-029 Reset mid-frame SHALL abort the frame with txd high; no gnt SHALL be issued for the aborted byte.
REQ-030 After rst rises, baud_tick SHALL first pulse at cycle DIV.

Verification
REQ-031 DIV=4: req0=1, data0=0xA5 -> gnt0 pulse; txd holds 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each for 64 cycles.
REQ-032 req0=req1=1 held continuously -> grants in order 0,1,0,1, each frame start 641 cycles apart.
REQ-033 div_load=1, div_val=8 mid-frame with DIV=4 -> current frame bits stay at 64 cycles; the next frame's bits are 128 cycles.
REQ-034 div_load with div_val=0 in IDLE -> baud_tick every 2 cycles; each bit lasts 32 cycles.
REQ-035 rst low during DATA bit 3 -> txd=1 and busy=0 immediately; after release, req1 alone -> gnt1, and the frame is correct.
